// File: rtl/ldpc_dec_types.sv
// Shared types and helpers for the LDPC decoder output path.
package ldpc_dec_types;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } bitcol_state_t;

    // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/ldpc_dec_bit_collector.sv
// Packs the variable-node engine's hard-decision bits LSB-first into words
// and counts per-frame hard-decision flips, reported with the last word.
module ldpc_dec_bit_collector
    import ldpc_dec_types::*;
#(
    parameter int unsigned pDAT_W     = 8,
    parameter int unsigned pERR_CNT_W = 16
) (
    input  logic                              iclk,
    input  logic                              ireset,
    input  logic                              iclkena,
    input  logic                              isop,
    input  logic                              ival,
    input  logic                              ieop,
    input  logic                              idat,
    input  logic                              ierr,
    output logic                              osop,
    output logic                              oval,
    output logic                              oeop,
    output logic [pDAT_W-1:0]                 odat,
    output logic [clog2(pDAT_W + 1)-1:0]      onum,
    output logic [pERR_CNT_W-1:0]             oerr_cnt
);

    localparam int unsigned IDX_W = clog2(pDAT_W);
    localparam int unsigned NUM_W = clog2(pDAT_W + 1);
    localparam logic [pERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(pDAT_W - 1);

    bitcol_state_t           state;
    logic [IDX_W-1:0]        idx;
    logic [pDAT_W-1:0]       sreg;
    logic [pERR_CNT_W-1:0]   cnt;
    logic                    first_pend;

    logic                    start_c;
    logic                    accept_c;
    logic                    emit_c;
    logic [IDX_W-1:0]        cur_idx_c;
    logic [pDAT_W-1:0]       word_c;
    logic [pERR_CNT_W-1:0]   cnt_base_c;
    logic [pERR_CNT_W-1:0]   cnt_next_c;

    // A sop bit restarts the frame from a clean slate, aborting any open one.
    always_comb begin
        start_c    = ival & isop;
        accept_c   = ival & (isop | (state == COLLECT));
        cur_idx_c  = start_c ? '0 : idx;
        word_c     = start_c ? '0 : sreg;
        word_c[cur_idx_c] = idat;
        cnt_base_c = start_c ? '0 : cnt;
        cnt_next_c = (ierr && (cnt_base_c != CNT_MAX)) ? cnt_base_c + pERR_CNT_W'(1) : cnt_base_c;
        emit_c     = accept_c & (ieop | (cur_idx_c == IDX_LAST));
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state      <= IDLE;
            idx        <= '0;
            sreg       <= '0;
            cnt        <= '0;
            first_pend <= 1'b0;
            osop       <= 1'b0;
            oval       <= 1'b0;
            oeop       <= 1'b0;
            odat       <= '0;
            onum       <= '0;
            oerr_cnt   <= '0;
        end else if (iclkena) begin
            oval <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
            if (accept_c) begin
                cnt   <= cnt_next_c;
                state <= ieop ? IDLE : COLLECT;
                if (emit_c) begin
                    oval       <= 1'b1;
                    osop       <= start_c | first_pend;
                    oeop       <= ieop;
                    odat       <= word_c;
                    onum       <= NUM_W'(cur_idx_c) + NUM_W'(1);
                    idx        <= '0;
                    sreg       <= '0;
                    first_pend <= 1'b0;
                    if (ieop) begin
                        oerr_cnt <= cnt_next_c;
                    end
                end else begin
                    sreg       <= word_c;
                    idx        <= cur_idx_c + IDX_W'(1);
                    first_pend <= start_c | first_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_ldpc_dec_bit_collector.sv
// Randomized/directed bench for the bit collector against a queue-based frame model.
module tb_ldpc_dec_bit_collector;

    localparam int unsigned DW = 8;

    logic            iclk = 1'b0;
    logic            ireset, iclkena, isop, ival, ieop, idat, ierr;
    logic            osop, oval, oeop;
    logic [DW-1:0]   odat;
    logic [3:0]      onum;
    logic [15:0]     oerr_cnt;
    logic            s_osop, s_oval, s_oeop;
    logic [DW-1:0]   s_odat;
    logic [3:0]      s_onum;
    logic [3:0]      s_oerr_cnt;

    always #5 iclk = ~iclk;

    ldpc_dec_bit_collector #(.pDAT_W(DW), .pERR_CNT_W(16)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
        .ieop(ieop), .idat(idat), .ierr(ierr), .osop(osop), .oval(oval), .oeop(oeop),
        .odat(odat), .onum(onum), .oerr_cnt(oerr_cnt)
    );

    ldpc_dec_bit_collector #(.pDAT_W(DW), .pERR_CNT_W(4)) dut_sat (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
        .ieop(ieop), .idat(idat), .ierr(ierr), .osop(s_osop), .oval(s_oval), .oeop(s_oeop),
        .odat(s_odat), .onum(s_onum), .oerr_cnt(s_oerr_cnt)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: open frame, bits of the word being filled, running flip count.
    bit          m_active = 1'b0;
    bit          m_first  = 1'b0;
    bit          m_q[$];
    int          m_cnt    = 0;
    bit          e_oval = 1'b0, e_osop = 1'b0, e_oeop = 1'b0;
    logic [7:0]  e_odat = '0;
    int          e_onum = 0, e_err16 = 0, e_err4 = 0;
    logic [7:0]  words[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_update(input bit rst, input bit ena, input bit sop, input bit val,
                                input bit eop, input bit dat, input bit err);
        if (rst) begin
            m_active = 0; m_first = 0; m_q.delete(); m_cnt = 0;
            e_oval = 0; e_osop = 0; e_oeop = 0; e_odat = '0; e_onum = 0; e_err16 = 0; e_err4 = 0;
        end else if (ena) begin
            e_oval = 0; e_osop = 0; e_oeop = 0;
            if (val && (sop || m_active)) begin
                if (sop) begin
                    m_q.delete(); m_cnt = 0; m_first = 1; m_active = 1;
                end
                m_q.push_back(dat);
                m_cnt += int'(err);
                if (eop || m_q.size() == DW) begin
                    e_odat = '0;
                    foreach (m_q[i]) e_odat[i] = m_q[i];
                    e_onum  = m_q.size();
                    e_oval  = 1;
                    e_osop  = m_first;
                    m_first = 0;
                    e_oeop  = eop;
                    if (eop) begin
                        e_err16  = (m_cnt > 65535) ? 65535 : m_cnt;
                        e_err4   = (m_cnt > 15) ? 15 : m_cnt;
                        m_active = 0;
                    end
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit ena, input bit sop, input bit val,
                        input bit eop, input bit dat, input bit err);
        ireset = rst; iclkena = ena; isop = sop; ival = val; ieop = eop; idat = dat; ierr = err;
        @(posedge iclk);
        model_update(rst, ena, sop, val, eop, dat, err);
        #1;
        chk("oval",     64'(oval),       64'(e_oval));
        chk("osop",     64'(osop),       64'(e_osop));
        chk("oeop",     64'(oeop),       64'(e_oeop));
        chk("odat",     64'(odat),       64'(e_odat));
        chk("onum",     64'(onum),       64'(e_onum));
        chk("oerr_cnt", 64'(oerr_cnt),   64'(e_err16));
        chk("sat_oval", 64'(s_oval),     64'(e_oval));
        chk("sat_err",  64'(s_oerr_cnt), 64'(e_err4));
        if (!rst && ena && oval === 1'b1) words.push_back(odat);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input int n, input logic [63:0] d, input logic [63:0] e, input int gap);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap) begin
                if ($urandom_range(3) == 0)
                    step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                else
                    step(0, 1, 0, 0, 0, 1'($urandom), 1'($urandom));
            end
            step(0, 1, i == 0, 1, i == n - 1, d[i], e[i]);
        end
    endtask

    initial begin
        logic [63:0] rd, re;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1);
        chk("reset_oval", 64'(oval), 64'd0);
        chk("reset_err",  64'(oerr_cnt), 64'd0);

        // Bits outside a frame are ignored.
        step(0, 1, 0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1, 1, 1);
        idle(1);

        words.delete();
        re = {$urandom, $urandom};
        send_frame(20, 64'hA5C3F, re, 20);
        idle(2);
        chk("f20_nwords", 64'(words.size()), 64'd3);
        if (words.size() == 3) begin
            chk("f20_w0", 64'(words[0]), 64'h3F);
            chk("f20_w1", 64'(words[1]), 64'h5C);
            chk("f20_w2", 64'(words[2]), 64'h0A);
        end

        words.delete();
        rd = {$urandom, $urandom};
        send_frame(16, rd, 64'h8021, 0);
        idle(2);
        chk("f16_nwords", 64'(words.size()), 64'd2);
        chk("f16_err",    64'(oerr_cnt), 64'd3);

        step(0, 1, 1, 1, 1, 1, 1);
        chk("f1_odat", 64'(odat), 64'h01);
        chk("f1_onum", 64'(onum), 64'd1);
        chk("f1_sop",  64'(osop), 64'd1);
        chk("f1_eop",  64'(oeop), 64'd1);
        chk("f1_err",  64'(oerr_cnt), 64'd1);
        idle(1);

        rd = {$urandom, $urandom};
        send_frame(40, rd, 64'hFF_FFFF_FFFF, 10);
        idle(1);
        chk("f40_sat",  64'(s_oerr_cnt), 64'd15);
        chk("f40_wide", 64'(oerr_cnt),   64'd40);

        // Missing eop: the partial first frame must never surface.
        words.delete();
        for (int i = 0; i < 5; i++) step(0, 1, i == 0, 1, 0, 1'($urandom), 1'($urandom));
        rd = {$urandom, $urandom};
        send_frame(8, rd, {$urandom, $urandom}, 0);
        idle(1);
        chk("abort_nwords", 64'(words.size()), 64'd1);
        if (words.size() == 1) chk("abort_word", 64'(words[0]), 64'(rd[7:0]));

        // Clock enable low mid-frame with noisy inputs.
        rd = {$urandom, $urandom};
        for (int i = 0; i < 12; i++) begin
            if (i == 4 || i == 8)
                for (int k = 0; k < 3; k++)
                    step(0, 0, 1'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom));
            step(0, 1, i == 0, 1, i == 11, rd[i], 1'($urandom));
        end
        step(0, 0, 1, 1, 1, 1, 1);
        idle(1);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 6; i++) step(0, 1, i == 0, 1, 0, 1'($urandom), 1'($urandom));
        step(1, 1, 0, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1, 1, 1);
        words.delete();
        send_frame(20, 64'hA5C3F, {$urandom, $urandom}, 0);
        idle(1);
        chk("post_rst_nwords", 64'(words.size()), 64'd3);
        if (words.size() == 3) chk("post_rst_w2", 64'(words[2]), 64'h0A);

        for (int f = 0; f < 30; f++) begin
            send_frame(int'($urandom_range(1, 40)), {$urandom, $urandom}, {$urandom, $urandom}, 25);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
